// File: rtl/shift_seq_pkg.sv
// Shared encodings and defaults for the multi-cycle shift controller.
package shift_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/result bundle between the ALU32 decode, the shift controller and the result mux.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op, data, shamt, abort, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, data, shamt, abort, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/shift_stage_var.sv
// One combinational shift stage whose distance is 2^stage_i, selected per output bit.
module shift_stage_var
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH),
    parameter int STW   = (SHW > 1) ? $clog2(SHW) : 1
) (
    input  logic [WIDTH-1:0] value_i,
    input  op_e              op_i,
    input  logic [STW-1:0]   stage_i,
    output logic [WIDTH-1:0] value_o
);

    logic [SHW-1:0] dist_s;
    logic [SHW-1:0] lo_idx_s;
    logic [SHW-1:0] hi_idx_s;

    assign dist_s = SHW'(1) << stage_i;

    // Index arithmetic wraps modulo WIDTH, so rotate falls out of the same mux as the shifts.
    always_comb begin
        value_o  = '0;
        lo_idx_s = '0;
        hi_idx_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lo_idx_s = SHW'(i) - dist_s;
            hi_idx_s = SHW'(i) + dist_s;
            case (op_i)
                OP_SLL:  value_o[i] = (i >= int'(dist_s)) ? value_i[lo_idx_s] : 1'b0;
                OP_SRL:  value_o[i] = (i + int'(dist_s) < WIDTH) ? value_i[hi_idx_s] : 1'b0;
                OP_SRA:  value_o[i] = (i + int'(dist_s) < WIDTH) ? value_i[hi_idx_s] : value_i[WIDTH-1];
                OP_ROR:  value_o[i] = value_i[hi_idx_s];
                default: value_o[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shifter: one request in, five fixed power-of-two steps (MSB first), result held until taken.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH),
    parameter int STW   = (SHW > 1) ? $clog2(SHW) : 1
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_ctrl_if.slave  bus
);

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    op_e              op_q,        op_d;
    logic [SHW-1:0]   shamt_q,     shamt_d;
    logic [STW-1:0]   stage_q,     stage_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;
    logic             busy_q,      busy_d;
    logic [WIDTH-1:0] stage_val_s;

    shift_stage_var #(.WIDTH(WIDTH), .SHW(SHW), .STW(STW)) u_stage (
        .value_i (acc_q),
        .op_i    (op_q),
        .stage_i (stage_q),
        .value_o (stage_val_s)
    );

    // abort must also block acceptance in the same cycle, hence the combinational gate.
    assign bus.in_ready  = in_ready_q & ~bus.abort;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;

    // Next-state and datapath update; abort outranks the handshake.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        shamt_d     = shamt_q;
        stage_d     = stage_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        if (bus.abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            acc_d       = '0;
            result_d    = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && !bus.abort) begin
                        acc_d      = bus.data;
                        op_d       = op_e'(bus.op);
                        shamt_d    = bus.shamt;
                        stage_d    = STW'(SHW - 1);
                        state_d    = SHIFT;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    if (shamt_q[stage_q]) begin
                        acc_d = stage_val_s;
                    end else begin
                        acc_d = acc_q;
                    end
                    if (stage_q == STW'(0)) begin
                        state_d     = DONE;
                        result_d    = acc_d;
                        out_valid_d = 1'b1;
                    end else begin
                        stage_d = stage_q - STW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= OP_SLL;
            shamt_q     <= '0;
            stage_q     <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            shamt_q     <= shamt_d;
            stage_q     <= stage_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

endmodule
